// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, sequencer state and event record
// for the scan controller and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;

    typedef enum logic [1:0] {
        StIdle,
        StPfxE0,
        StPfxF0,
        StPfxE0F0
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    // Controller/status bytes that never form part of a key event.
    function automatic logic ps2_is_status(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) ||
               (b == PS2_ECHO) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO; a pop frees the head slot in the same cycle,
// so push and pop together are accepted even when full.
import ps2_pkg::*;

module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ps2_event_t               wdata,
    input  logic                     pop,
    output ps2_event_t               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    ps2_event_t    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scancode sequencer: prefix stripping, event FIFO and display registers.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes of a held key.
import ps2_pkg::*;

module ps2_scan_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] curr_code,
    output logic [7:0] prev_code,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    ps2_state_e            state_q, state_d;
    logic [CW-1:0]         tmo_q;
    logic                  timeout;
    logic                  evt_gen, push, suppress, pop, drop;
    ps2_event_t            evt, head;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [7:0]            curr_q, prev_q;
    logic                  ovf_q;

    assign timeout = (state_q != StIdle) && (tmo_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // E0 always (re)starts an extended sequence; F0 keeps any E0 already seen.
    always_comb begin
        state_d = state_q;
        if (rx_err) begin
            state_d = StIdle;
        end else if (rx_valid) begin
            if (rx_data == PS2_EXT) begin
                state_d = StPfxE0;
            end else if (rx_data == PS2_BRK) begin
                state_d = (state_q == StPfxE0 || state_q == StPfxE0F0) ? StPfxE0F0 : StPfxF0;
            end else begin
                state_d = StIdle;
            end
        end else if (timeout) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        evt_gen  = rx_valid && !rx_err && (rx_data != PS2_EXT) && (rx_data != PS2_BRK) &&
                   !ps2_is_status(rx_data);
        evt.ext  = (state_q == StPfxE0) || (state_q == StPfxE0F0);
        evt.brk  = (state_q == StPfxF0) || (state_q == StPfxE0F0);
        evt.code = rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            tmo_q <= '0;
        else if (state_q == StIdle || rx_valid) tmo_q <= '0;
        else                                   tmo_q <= tmo_q + 1'b1;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid_q;
    logic       held_ext_q;
    logic [7:0] held_code_q;
    logic       held_match;

    assign held_match = held_valid_q && (held_ext_q == evt.ext) && (held_code_q == evt.code);
    assign suppress   = evt_gen && !evt.brk && held_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            held_ext_q   <= 1'b0;
            held_code_q  <= '0;
        end else if (evt_gen && !evt.brk && !held_match) begin
            held_valid_q <= 1'b1;
            held_ext_q   <= evt.ext;
            held_code_q  <= evt.code;
        end else if (evt_gen && evt.brk && held_match) begin
            held_valid_q <= 1'b0;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign push = evt_gen && !suppress;
    assign pop  = ev_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    ps2_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (evt),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_q <= '0;
            prev_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push && !evt.brk) begin
                prev_q <= curr_q;
                curr_q <= evt.code;
            end
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign ev_code   = head.code;
    assign ev_ext    = head.ext;
    assign ev_brk    = head.brk;
    assign ev_valid  = (fifo_count != '0);
    assign curr_code = curr_q;
    assign prev_code = prev_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl: handshakes are logged by a monitor and
// compared against hand-computed {ext, brk, code} events.
module tb_ps2_scan_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err, ev_ready, ovf_clr;
    logic [7:0] ev_code, curr_code, prev_code;
    logic       ev_ext, ev_brk, ev_valid, ovf;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] got[$];

    ps2_scan_ctrl #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_brk    (ev_brk),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .curr_code (curr_code),
        .prev_code (prev_code),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Log accepted events 1 ns before the rising edge, when inputs are settled.
    always begin
        @(negedge clk);
        #4;
        if (ev_valid && ev_ready) got.push_back({ev_ext, ev_brk, ev_code});
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 10'h3FF;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
        ev_ready = 1'b1; ovf_clr = 1'b0;
        idle(3);
        check("rst_valid", ev_valid, 0);
        check("rst_code",  {ev_ext, ev_brk, ev_code}, 0);
        check("rst_curr",  curr_code, 0);
        check("rst_prev",  prev_code, 0);
        check("rst_ovf",   ovf, 0);
        rst_n = 1'b1;
        idle(2);

        // Plain makes and display shift
        send(8'h3A); send(8'h11); idle(3);
        check("mk_cnt",  got.size(), 2);
        check("mk_ev0",  got_at(0), 10'h03A);
        check("mk_ev1",  got_at(1), 10'h011);
        check("mk_curr", curr_code, 8'h11);
        check("mk_prev", prev_code, 8'h3A);

        // Extended break leaves display alone
        got.delete();
        send(8'hE0); send(8'hF0); send(8'h75); idle(3);
        check("eb_cnt",  got.size(), 1);
        check("eb_ev",   got_at(0), 10'h375);
        check("eb_curr", curr_code, 8'h11);
        check("eb_prev", prev_code, 8'h3A);

        // Timeout: just inside the window still a break, full window abandons it
        got.delete();
        send(8'hF0); idle(TMO - 2); send(8'h1C); idle(2);
        send(8'hF0); idle(TMO);     send(8'h1C); idle(3);
        check("to_cnt",  got.size(), 2);
        check("to_brk",  got_at(0), 10'h11C);
        check("to_make", got_at(1), 10'h01C);
        check("to_curr", curr_code, 8'h1C);

        // rx_err abort, status bytes, rx_err priority over rx_valid
        got.delete();
        send(8'hE0);
        rx_err = 1'b1; idle(1); rx_err = 1'b0;
        send(8'h6B); send(8'hAA); send(8'hFA);
        send(8'hE0); send(8'hAA); send(8'h22);
        rx_err = 1'b1; send(8'h5A); rx_err = 1'b0;
        idle(3);
        check("er_cnt", got.size(), 2);
        check("er_ev0", got_at(0), 10'h06B);
        check("er_ev1", got_at(1), 10'h022);

        // Overflow with consumer stalled
        got.delete();
        ev_ready = 1'b0;
        send(8'h21); check("lat_valid", ev_valid, 1);
        send(8'h22); send(8'h23); send(8'h24); idle(1);
        check("full_noovf", ovf, 0);
        send(8'h25); idle(1);
        check("ovf_set",  ovf, 1);
        check("ovf_head", {ev_ext, ev_brk, ev_code}, 10'h021);
        check("stall_cnt", got.size(), 0);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);
        ev_ready = 1'b1; idle(6);
        ev_ready = 1'b0;
        check("ov_cnt", got.size(), 4);
        check("ov_ev0", got_at(0), 10'h021);
        check("ov_ev3", got_at(3), 10'h024);

        // Push and pop together while full
        got.delete();
        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        ev_ready = 1'b1; send(8'h35); idle(6);
        check("pp_ovf", ovf, 0);
        check("pp_cnt", got.size(), 5);
        check("pp_ev0", got_at(0), 10'h031);
        check("pp_ev4", got_at(4), 10'h035);
        check("pp_empty", ev_valid, 0);

        // Auto-repeat stream
        got.delete();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        idle(4);
        check("tm_ev0", got_at(0), 10'h01C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("tm_cnt", got.size(), 3);
        check("tm_ev1", got_at(1), 10'h11C);
        check("tm_ev2", got_at(2), 10'h01C);
`else
        check("tm_cnt", got.size(), 5);
        check("tm_ev2", got_at(2), 10'h01C);
        check("tm_ev3", got_at(3), 10'h11C);
        check("tm_ev4", got_at(4), 10'h01C);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Sequences the byte stream from the PS/2 frame receiver into complete key events: make or break, extended or normal.
- Strips the 0xE0 and 0xF0 prefixes and drops controller/status bytes.
- Buffers events in a small FIFO for the consumer.
- Maintains the current/previous make-code registers that feed the seven-segment display decoders.

Parameters:
- DEPTH, 4, event FIFO depth; must be a power of 2, and at least 2.
- TIMEOUT_CYC, 50000, clk cycles allowed between a prefix byte and the next byte before the partial sequence is abandoned.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received scancode byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe from the frame receiver; rx_data is good.
- rx_err  in  1  one-cycle strobe: parity or stop-bit error on the last frame.
- ev_code  out  8  head event: base scancode.
- ev_ext  out  1  head event: 0xE0 prefix was present.
- ev_brk  out  1  head event: 0xF0 prefix was present (key release).
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head event when ev_valid&&ev_ready.
- curr_code  out  8  most recent make code, for display.
- prev_code  out  8  make code before curr_code, for display.
- ovf  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO empty, so ev_valid=0.
  - ev_code=0, ev_ext=0, ev_brk=0.
  - curr_code=0, prev_code=0, ovf=0; timeout counter=0.
- FSM states: IDLE, PFX_E0, PFX_F0, PFX_E0F0. The FSM advances only on cycles where rx_valid=1.
- IDLE transitions:
  - 0xE0 -> PFX_E0.
  - 0xF0 -> PFX_F0.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF -> dropped; stay in IDLE.
  - Any other byte -> push {ext=0, brk=0, code}.
- PFX_E0 transitions:
  - 0xF0 -> PFX_E0F0.
  - 0xE0 -> stay in PFX_E0.
  - Other byte -> push {1, 0, code}; go to IDLE.
- PFX_F0 transitions:
  - 0xF0 -> stay in PFX_F0.
  - 0xE0 -> PFX_E0 (restart the sequence).
  - Other byte -> push {0, 1, code}; go to IDLE.
- PFX_E0F0 transitions:
  - 0xE0 -> PFX_E0.
  - 0xF0 -> stay in PFX_E0F0.
  - Other byte -> push {1, 1, code}; go to IDLE.
- A status byte (0xAA etc.) received in any prefix state -> dropped; go to IDLE.
- rx_err: in any state, go to IDLE and generate no event. rx_err takes priority over a simultaneous rx_valid.
- Timeout:
  - The counter clears on every rx_valid and whenever the state is IDLE.
  - In any non-IDLE state, when the count reaches TIMEOUT_CYC-1, the FSM goes to IDLE with no event.
- Latency:
  - An rx_valid in cycle N that completes an event makes ev_valid=1 in cycle N+1 if the FIFO was empty.
  - curr_code and prev_code update in cycle N+1 for non-break events: prev_code<=curr_code, curr_code<=code. Break events never touch the display registers.
- FIFO:
  - Show-ahead: ev_* always reflect the head entry.
  - A pop occurs when ev_valid&&ev_ready.
  - Push and pop in the same cycle: both happen, and the occupancy is unchanged. This also holds when the FIFO is full (the pop frees the slot first).
  - Push when full with no pop: the new event is dropped and ovf<=1.
  - ovf_clr clears ovf. If ovf_clr and a new drop occur in the same cycle, ovf=1 (set wins).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate count of log2(DEPTH)+1 bits distinguishes full from empty.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - An 8-bit held_code register plus a held_ext bit track the last make key.
  - A make event whose {ext, code} equals the held key while it is still held is suppressed: no push, no display update.
  - A break event whose {ext, code} equals the held key clears the held state.
  - The held state resets to "none".
- Undefined: every make event is pushed, including auto-repeat makes, and each one updates the display.

Decomposition:
- Package ps2_pkg contains:
  - Byte constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_ECHO=8'hEE.
  - The FSM state enum.
  - The 10-bit event struct {ext, brk, code[7:0]}.
- Sub-module ps2_evt_fifo: a parameterised show-ahead FIFO with push, pop, full, empty and count outputs.

Test Plan:
- Send 0x3A, then 0x11 -> two events {0,0,3A} and {0,0,11}; after both, curr_code=0x11 and prev_code=0x3A.
- Send E0 F0 75 -> one event {1,1,0x75}; curr_code and prev_code unchanged.
- Send F0, then idle for TIMEOUT_CYC cycles, then 1C -> event {0,0,0x1C}, not a break.
- Hold ev_ready=0 and send DEPTH+1 make codes -> first DEPTH events retained, ovf=1; pulse ovf_clr -> ovf=0.
- Send E0, then rx_err, then 6B -> single event {0,0,0x6B}. Send AA and FA -> no events.
- With PS2_TYPEMATIC_FILTER_EN defined, send 1C 1C 1C F0 1C 1C -> events make 1C, break 1C, make 1C (3 total). With the macro undefined -> 5 events.
